// File: rtl/mux_pkg.sv
// Shared types for the pipelined N-way selector: handshake state encoding.
package mux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } mux_state_t;

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N-way word selector; out-of-range selects yield a zero word and err.
module mux_n_comb #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N*WIDTH-1:0] data,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   word,
   output logic               err
);

   // Matching against each legal index avoids a variable part-select past the last input.
   always_comb begin
      word = '0;
      err  = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (sel == SEL_W'(k)) begin
            word = data[k*WIDTH +: WIDTH];
            err  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way word selector with valid/ready handshake and a one-entry skid buffer.
module mux_n_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_err,
   output logic               out_valid,
   input  logic               out_ready
);

   mux_state_t       state;
   mux_state_t       next_state;
   logic [WIDTH-1:0] main_data;
   logic             main_err;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;
   logic [WIDTH-1:0] sel_word;
   logic             sel_err;
   logic             in_xfer;
   logic             out_xfer;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   mux_n_comb #(
      .WIDTH (WIDTH),
      .N     (N),
      .SEL_W (SEL_W)
   ) u_sel (
      .data (in_data),
      .sel  (in_sel),
      .word (sel_word),
      .err  (sel_err)
   );

   // Handshakes come from registered state only, so out_ready never reaches in_ready.
   assign in_ready  = rst_n && (state != FULL);
   assign out_valid = rst_n && (state != EMPTY);
   assign out_data  = main_data;
   assign out_err   = main_err;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      next_state     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               load_main_in = 1'b1;
               next_state   = BUSY;
            end
         end
         BUSY: begin
            if (in_xfer && out_xfer) begin
               load_main_in = 1'b1;
            end else if (in_xfer) begin
               load_skid  = 1'b1;
               next_state = FULL;
            end else if (out_xfer) begin
               next_state = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               load_main_skid = 1'b1;
               next_state     = BUSY;
            end
         end
         default: next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         main_data <= '0;
         main_err  <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
      end else begin
         state <= next_state;
         if (load_main_in) begin
            main_data <= sel_word;
            main_err  <= sel_err;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_err  <= skid_err;
         end
         if (load_skid) begin
            skid_data <= sel_word;
            skid_err  <= sel_err;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe (N=5, WIDTH=8): directed cases, reset while full, random handshake soak.
module tb_mux_n_pipe;
   localparam int N     = 5;
   localparam int WIDTH = 8;
   localparam int SEL_W = $clog2(N);

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]   in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_err;
   logic               out_valid;
   logic               out_ready;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH:0]   sb[$];
   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic             prev_err;
   logic [WIDTH:0]   exp_beat;
   logic [N*WIDTH-1:0] base_data;

   always #5 clk = ~clk;

   mux_n_pipe #(
      .WIDTH (WIDTH),
      .N     (N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference selection: {err, word}
   function automatic logic [WIDTH:0] modelSelect(input logic [N*WIDTH-1:0] d, input logic [SEL_W-1:0] s);
      logic [WIDTH:0] r;
      r = {1'b1, {WIDTH{1'b0}}};
      if (int'(s) < N) r = {1'b0, d[int'(s)*WIDTH +: WIDTH]};
      return r;
   endfunction

   // One clock cycle: drive on the falling edge, check and update the scoreboard 1ns later.
   task automatic applyStimulus(input logic iv, input logic [N*WIDTH-1:0] d,
                                input logic [SEL_W-1:0] s, input logic ordy);
      int occ;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      in_sel    = s;
      out_ready = ordy;
      #1;
      occ = sb.size();
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, occ < 2});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
      if (stall_prev && out_valid) begin
         checkOutput("stall_data", {24'd0, out_data}, {24'd0, prev_data});
         checkOutput("stall_err", {31'd0, out_err}, {31'd0, prev_err});
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_beat = sb.pop_front();
            checkOutput("out_data", {24'd0, out_data}, {24'd0, exp_beat[WIDTH-1:0]});
            checkOutput("out_err", {31'd0, out_err}, {31'd0, exp_beat[WIDTH]});
         end
      end
      if (in_valid && in_ready) sb.push_back(modelSelect(d, s));
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_err   = out_err;
   endtask

   task automatic doReset(input int cycles);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (cycles) @(posedge clk);
      #1;
      checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
      checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
      checkOutput("rst_out_valid_q", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_in_ready_q", {31'd0, in_ready}, 32'd0);
      sb.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      out_ready = 1'b0;
      base_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

      doReset(2);

      // Single beat, sel=2, then drain
      applyStimulus(1'b1, base_data, 3'd2, 1'b1);
      applyStimulus(1'b0, base_data, 3'd0, 1'b1);
      applyStimulus(1'b0, base_data, 3'd0, 1'b1);

      // Boundary selects: last legal index, first illegal, then legal again
      applyStimulus(1'b1, base_data, 3'd4, 1'b1);
      applyStimulus(1'b1, base_data, 3'd5, 1'b1);
      applyStimulus(1'b1, base_data, 3'd7, 1'b1);
      applyStimulus(1'b1, base_data, 3'd1, 1'b1);
      applyStimulus(1'b0, base_data, 3'd0, 1'b1);
      applyStimulus(1'b0, base_data, 3'd0, 1'b1);

      // Streaming: 8 beats back to back
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, base_data ^ {N{8'(i * 8'h13)}}, SEL_W'(i % 4), 1'b1);
      applyStimulus(1'b0, base_data, 3'd0, 1'b1);
      applyStimulus(1'b0, base_data, 3'd0, 1'b1);

      // Backpressure: A accepted, B into skid, C held off until space returns
      applyStimulus(1'b1, {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0}, 3'd0, 1'b1);
      applyStimulus(1'b1, {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0}, 3'd1, 1'b0);
      applyStimulus(1'b1, {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}, 3'd2, 1'b0);
      applyStimulus(1'b1, {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}, 3'd2, 1'b0);
      applyStimulus(1'b1, {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}, 3'd2, 1'b1);
      applyStimulus(1'b1, {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}, 3'd2, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, base_data, 3'd0, 1'b1);
      checkOutput("bp_drained", sb.size(), 32'd0);

      // Fill to FULL, then reset: stale beats must never reappear
      applyStimulus(1'b1, base_data, 3'd3, 1'b0);
      applyStimulus(1'b1, base_data, 3'd4, 1'b0);
      applyStimulus(1'b0, base_data, 3'd0, 1'b0);
      doReset(1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, base_data, 3'd0, 1'b1);
      applyStimulus(1'b1, base_data, 3'd0, 1'b1);
      applyStimulus(1'b0, base_data, 3'd0, 1'b1);

      // Random handshake soak
      for (int i = 0; i < 10000; i++)
         applyStimulus($urandom_range(0, 9) < 7, {$urandom(), $urandom()} & {N*WIDTH{1'b1}},
                       SEL_W'($urandom_range(0, 7)), $urandom_range(0, 9) < 6);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, base_data, 3'd0, 1'b1);
      checkOutput("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised, pipelined N-way word selector; the registered successor of the 2:1 datapath mux, used between execute-stage result sources and the writeback path. One of N WIDTH-bit inputs is picked by a binary select and captured into an output register behind a valid/ready handshake. A one-entry skid buffer gives full throughput without a combinational path from `out_ready` to `in_ready`. Out-of-range selects are flagged.

## Interface
- `WIDTH`, 32, data word width in bits (≥1)
- `N`, 4, number of inputs (≥2, need not be a power of two)
- `SEL_W`, `$clog2(N)`, select width (derived; not overridden)

- `clk`  in  1  rising-edge clock; single clock domain
- `rst_n`  in  1  synchronous, active-low reset
- `in_data`  in  N*WIDTH  packed inputs; input k is `in_data[k*WIDTH +: WIDTH]`
- `in_sel`  in  SEL_W  binary select, sampled with the input beat
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  block can accept a beat this cycle
- `out_data`  out  WIDTH  selected word
- `out_err`  out  1  beat was captured with `in_sel >= N`
- `out_valid`  out  1  `out_data`/`out_err` hold a beat
- `out_ready`  in  1  consumer accepts the output beat

## Operation
- Input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- On input transfer, selected word is `in_data[in_sel*WIDTH +: WIDTH]` if `in_sel < N`; otherwise word is all-zero and err bit is 1.
- Storage: main register (drives outputs) and skid register, each holding {data, err}.
- State machine (3 states):
  - EMPTY: `out_valid=0`. Input transfer -> main, go BUSY.
  - BUSY: `out_valid=1`, skid empty. Input and output transfer -> main reloads, stay BUSY. Input only -> skid, go FULL. Output only -> EMPTY. Neither -> hold.
  - FULL: `out_valid=1`, `in_ready=0`. Output transfer -> main takes skid, go BUSY. Otherwise hold.
- `in_ready = rst_n && (state != FULL)`; depends only on registered state.
- Beats leave in arrival order; none dropped or duplicated.
- `out_data`/`out_err` stable while `out_valid && !out_ready`.
- `in_sel`/`in_data` ignored when no input transfer occurs.

## Timing
- Latency: input transfer in cycle t -> `out_valid=1` with that beat in cycle t+1 (from EMPTY or BUSY-with-drain).
- Throughput: one beat per cycle with `out_ready` held high.
- Reset (`rst_n=0` sampled at edge): state EMPTY, `out_valid=0`, `out_data=0`, `out_err=0`, skid cleared to 0; `in_ready=0` while `rst_n` low, 1 on the first cycle after release.
- Reset mid-operation: both stored beats discarded; no output transfer in the reset cycle.
- After `out_ready` deasserts in BUSY, at most one further beat is accepted (into skid); `in_ready` falls the next cycle.
- FULL with `out_ready=1`: skid moves to main, `in_ready` rises next cycle; no new input accepted in that cycle.

## Structure
- Shared package `mux_pkg`: state enum `mux_state_t` {EMPTY, BUSY, FULL}, 2-bit encoding.
- Sub-module `mux_n_comb`: pure combinational N-way selector (parameters WIDTH, N) producing word and err; instantiated once at the input side.
- Top holds state register, main and skid registers, handshake logic.

## Test plan
- N=4, WIDTH=32, inputs 0x11111111/0x22222222/0x33333333/0x44444444, `in_sel=2`, `out_ready=1` -> next cycle `out_data=0x33333333`, `out_err=0`, `out_valid=1`.
- N=3, `in_sel=3` -> `out_data=0`, `out_err=1`; following beat `in_sel=1` -> input 1 word, `out_err=0`.
- Stream 8 beats sel 0..3 repeating, `out_ready=1` -> one beat/cycle, order preserved, `in_ready` constant 1.
- Backpressure: `out_ready=0` after beat A accepted, present B then C -> B to skid, `in_ready=0`, C held off; `out_ready=1` -> A, B, C delivered in order, no loss.
- Reset pulse (`rst_n=0` one cycle) while FULL -> `out_valid=0`, `out_data=0`, `in_ready=0` during reset, `in_ready=1` next cycle; stale beats never appear.
- Random `in_valid`/`out_ready` for 10k cycles vs scoreboard model, N=5, WIDTH=8 -> exact in-order match, outputs stable under stall.
